regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (we3/a3/wd3) between NREQ writeback requesters, for example the ALU result path and the load-return path.
- Arbitration is round-robin with a valid/ready handshake per requester.
- The write command is registered, so writes reach the register file one cycle after grant.
- Writes to register 0 are accepted and then dropped, since register 0 always reads as 0.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 49 ++++
 tb/tb_regfile_wb_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry and shared address/data types
package regfile_pkg;
    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NREG     = 32;
    localparam int ZERO_REG = 0;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; one-hot grant searched from a rotating pointer
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N-1:0]                  req,
    output logic [N-1:0]                  gnt,
    output logic [$clog2(N>1?N:2)-1:0]    gnt_idx
);
    localparam int IW = $clog2(N > 1 ? N : 2);
    logic [IW-1:0] ptr;
    // Descending scan so the index closest to ptr overwrites the others
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                         = '0;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                gnt_idx                     = IW'((int'(ptr) + k) % N);
            end
        end
        if (!rst_n) gnt = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (|gnt) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register file write port among writeback requesters
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*AW-1:0]              req_addr,
    input  logic [NREQ*DW-1:0]              req_data,
    output logic [NREQ-1:0]                 req_ready,
    output logic                            we3,
    output logic [AW-1:0]                   a3,
    output logic [DW-1:0]                   wd3,
    output logic [$clog2(NREQ>1?NREQ:2)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ > 1 ? NREQ : 2);
    logic [IW-1:0] g;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (g)
    );
    assign gaddr = req_addr[g*AW +: AW];
    assign gdata = req_data[g*DW +: DW];
    // Register 0 writes are consumed but never reach the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            grant_id <= '0;
        end else begin
            we3 <= |req_ready && gaddr != AW'(ZERO_REG);
            if (|req_ready) begin
                a3       <= gaddr;
                wd3      <= gdata;
                grant_id <= g;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grants, write port timing, register 0 and async reset
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [0:0]  grant_id;
    int n_chk = 0;
    int n_fail = 0;
    reg_data_t rf [NREG];

    regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (we3) begin
            rf[a3] <= wd3;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set(input logic [1:0] v, input logic [4:0] ad0, input logic [31:0] d0,
                       input logic [4:0] ad1, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {ad1, ad0};
        req_data  = {d1, d0};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic gid);
        check({tag, ".we3"}, 64'(we3), 64'(w));
        check({tag, ".a3"}, 64'(a3), 64'(a));
        check({tag, ".wd3"}, 64'(wd3), 64'(d));
        check({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
    endtask

    initial begin
        set(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
        #3;
        check("rst_ready", 64'(req_ready), 64'd0);
        outs("rst", 1'b0, 5'd0, 32'd0, 1'b0);
        #20;
        check("rst_ready_hold", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("fair_ready", 64'(req_ready), (i % 2) ? 64'd2 : 64'd1);
            step();
            outs("fair", 1'b1, (i % 2) ? 5'd4 : 5'd3, (i % 2) ? 32'h22 : 32'h11, 1'(i % 2));
            #1;
        end
        set(2'b00, 5'd3, 32'h11, 5'd4, 32'h22);
        #1;
        check("idle_ready", 64'(req_ready), 64'd0);
        step();
        outs("idle", 1'b0, 5'd4, 32'h22, 1'b1);
        set(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        check("single_ready", 64'(req_ready), 64'd1);
        step();
        outs("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        set(2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        step();
        outs("single_after", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
        set(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
        #1;
        check("r0_ready", 64'(req_ready), 64'd2);
        step();
        outs("r0", 1'b0, 5'd0, 32'h1234, 1'b1);
        set(2'b11, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB);
        #1;
        check("r0_ptr_adv", 64'(req_ready), 64'd1);
        step();
        outs("same0", 1'b1, 5'd7, 32'hAAAA, 1'b0);
        set(2'b10, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB);
        #1;
        check("same_ready1", 64'(req_ready), 64'd2);
        step();
        outs("same1", 1'b1, 5'd7, 32'hBBBB, 1'b1);
        set(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        check("rf7", 64'(rf[7]), 64'hBBBB);
        check("rf5", 64'(rf[5]), 64'hDEADBEEF);
        check("rf0", 64'(rf[0]), 64'h0);
        set(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
        step();
        outs("pre_rst", 1'b1, 5'd9, 32'h99, 1'b0);
        set(2'b00, 5'd9, 32'h99, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        outs("async_rst", 1'b0, 5'd0, 32'd0, 1'b0);
        set(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        #1;
        check("async_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ptr", 64'(req_ready), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
